// File: rtl/nprime0_calc_pkg.sv
// rtl/nprime0_calc_pkg.sv - shared constants, state encoding and helpers for nprime0_calc
package nprime0_calc_pkg;

    // Word width used when the instantiating context does not override it.
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Iteration counter width: clog2 of the word width, never below one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/nprime0_calc.sv
// rtl/nprime0_calc.sv - bit-serial Montgomery constant n'0 = -n0^-1 mod 2^W with one-word write port
//
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-high reset
//   start   - request a computation (accepted when no computation is running)
//   n0      - least-significant modulus word, latched when start is accepted
//   busy    - computation in progress
//   done    - one-cycle pulse: result or error valid
//   err     - n0 was even (no inverse); held until the next accepted start
//   nprime0 - result register, held until the next successful computation
//   wren    - write strobe to the nprime0 memory (done & ~err)
//   address - nprime0 memory address, always 0
//   data    - nprime0 memory write data, equals nprime0
module nprime0_calc
    import nprime0_calc_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] n0,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] nprime0,
    output logic                  wren,
    output logic                  address,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int              CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] t_q, t_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic [DATA_WIDTH-1:0] n_q, n_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] nprime0_q, nprime0_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            t_q       <= '0;
            r_q       <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            nprime0_q <= '0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            r_q       <= r_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            nprime0_q <= nprime0_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        r_d       = r_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        nprime0_d = nprime0_q;

        case (state_q)
            // DONE lasts one cycle and behaves like IDLE for start, so a held
            // start yields one result every W+1 cycles.
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    n_d   = n0;
                    t_d   = '0;
                    r_d   = '0;
                    cnt_d = '0;
                    if (!n0[0]) begin
                        // Even modulus word has no inverse mod 2^W.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                // Force bit cnt of t to 1 by adding n shifted into that
                // position; the shift and sum both truncate to W bits.
                if (!t_q[cnt_q]) begin
                    t_d        = t_q + (n_q << cnt_q);
                    r_d[cnt_q] = 1'b1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    nprime0_d = r_d;
                    state_d   = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;
    assign wren    = done & ~err_q;
    assign address = 1'b0;
    assign nprime0 = nprime0_q;
    assign data    = nprime0_q;

endmodule

// File: tb/tb_nprime0_calc.sv
// tb/tb_nprime0_calc.sv - directed self-checking bench for nprime0_calc
module tb_nprime0_calc;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] n0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] nprime0;
    logic        wren;
    logic        address;
    logic [31:0] data;

    int vectors;
    int errors;

    nprime0_calc #(.DATA_WIDTH(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .n0      (n0),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .nprime0 (nprime0),
        .wren    (wren),
        .address (address),
        .data    (data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present start for exactly one rising edge; returns at the falling edge after it.
    task automatic start_op(input logic [31:0] v);
        @(negedge clock);
        start = 1'b1;
        n0    = v;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Count rising edges until done is seen (edges = -1 on timeout); flags busy&done overlap.
    task automatic wait_done(output int edges, output bit overlap);
        edges   = 0;
        overlap = 1'b0;
        while (!done && edges < 100) begin
            if (busy && done) overlap = 1'b1;
            @(negedge clock);
            edges++;
        end
        if (busy && done) overlap = 1'b1;
        if (!done) edges = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        n0    = '0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({busy, done, err, wren, address} !== 5'b0 || nprime0 !== 32'h0 || data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b err=%b wren=%b addr=%b nprime0=%h data=%h, required all 0",
                     busy, done, err, wren, address, nprime0, data);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic(input logic [31:0] v, input logic [31:0] exp);
        int edges;
        bit ov;
        start_op(v);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy n0=%h: busy=%b, required 1", v, busy);
        end
        wait_done(edges, ov);
        vectors++;
        if (edges !== 32) begin
            errors++;
            $display("FAIL basic_latency n0=%h: %0d edges, required 32", v, edges);
        end
        vectors++;
        if (nprime0 !== exp || data !== exp || wren !== 1'b1 || err !== 1'b0 || address !== 1'b0 || ov) begin
            errors++;
            $display("FAIL basic_result n0=%h: nprime0=%h data=%h wren=%b err=%b addr=%b ov=%b, required %h/%h/1/0/0/0",
                     v, nprime0, data, wren, err, address, ov, exp, exp);
        end
        @(negedge clock);
        vectors++;
        if (done !== 1'b0 || wren !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse n0=%h: done=%b wren=%b busy=%b after one cycle, required 0/0/0", v, done, wren, busy);
        end
    endtask

    task automatic test_random();
        int edges;
        bit ov;
        logic [31:0] v;
        logic [31:0] prod;
        for (int i = 0; i < 1000; i++) begin
            v = $urandom() | 32'h1;
            start_op(v);
            wait_done(edges, ov);
            prod = v * nprime0;
            vectors++;
            if (prod !== 32'hFFFF_FFFF || edges !== 32 || ov) begin
                errors++;
                $display("FAIL random_inverse n0=%h: n0*nprime0=%h edges=%0d ov=%b, required ffffffff/32/0",
                         v, prod, edges, ov);
            end
        end
    endtask

    task automatic test_even();
        logic [31:0] prev;
        prev = 32'h5555_5555;
        test_basic(32'h3, prev);
        start_op(32'h2);
        vectors++;
        if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || wren !== 1'b0 || nprime0 !== prev) begin
            errors++;
            $display("FAIL even_done: done=%b err=%b busy=%b wren=%b nprime0=%h, required 1/1/0/0/%h",
                     done, err, busy, wren, nprime0, prev);
        end
        @(negedge clock);
        vectors++;
        if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0 || nprime0 !== prev) begin
            errors++;
            $display("FAIL even_hold: done=%b err=%b busy=%b nprime0=%h, required 0/1/0/%h", done, err, busy, nprime0, prev);
        end
        start_op(32'h1);
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL even_err_clear: err=%b busy=%b after odd start, required 0/1", err, busy);
        end
        while (!done) @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_ignore_start();
        int edges;
        bit ov;
        start_op(32'h3);
        edges = 0;
        ov    = 1'b0;
        while (!done && edges < 100) begin
            if (edges == 5 || edges == 20) begin
                start = 1'b1;
                n0    = 32'h1;
            end else begin
                start = 1'b0;
            end
            if (busy && done) ov = 1'b1;
            @(negedge clock);
            edges++;
        end
        start = 1'b0;
        vectors++;
        if (edges !== 32 || nprime0 !== 32'h5555_5555 || ov) begin
            errors++;
            $display("FAIL ignore_start: edges=%0d nprime0=%h ov=%b, required 32/55555555/0", edges, nprime0, ov);
        end
        // A start presented while done is high is taken on the following edge.
        start = 1'b1;
        n0    = 32'h5;
        @(negedge clock);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL accept_after_done: busy=%b done=%b, required 1/0", busy, done);
        end
        wait_done(edges, ov);
        vectors++;
        if (edges !== 32 || nprime0 !== 32'h3333_3333) begin
            errors++;
            $display("FAIL accept_after_done_result: edges=%0d nprime0=%h, required 32/33333333", edges, nprime0);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        start_op(32'h3);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, err, wren, address} !== 5'b0 || nprime0 !== 32'h0 || data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b err=%b wren=%b addr=%b nprime0=%h, required all 0",
                     busy, done, err, wren, address, nprime0);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) saw_done = 1'b1;
            if (i == 2) reset = 1'b0;
        end
        vectors++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_no_done: done/busy seen=%b after reset, required 0", saw_done);
        end
        test_basic(32'hFFFF_FFFF, 32'h0000_0001);
    endtask

    task automatic test_back_to_back();
        int pos[3];
        int found;
        @(negedge clock);
        start = 1'b1;
        n0    = 32'h1;
        found = 0;
        for (int i = 0; i < 150 && found < 3; i++) begin
            @(negedge clock);
            if (done) begin
                pos[found] = i;
                found++;
            end
        end
        start = 1'b0;
        vectors++;
        if (found !== 3) begin
            errors++;
            $display("FAIL b2b_count: %0d done pulses, required 3", found);
        end else begin
            vectors++;
            if (pos[1] - pos[0] !== 33 || pos[2] - pos[1] !== 33) begin
                errors++;
                $display("FAIL b2b_spacing: spacing %0d and %0d, required 33 and 33", pos[1] - pos[0], pos[2] - pos[1]);
            end
        end
        vectors++;
        if (nprime0 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL b2b_result: nprime0=%h, required ffffffff", nprime0);
        end
        for (int i = 0; i < 40 && (busy || done); i++) @(negedge clock);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_basic(32'h0000_0001, 32'hFFFF_FFFF);
        test_basic(32'h0000_0003, 32'h5555_5555);
        test_basic(32'hFFFF_FFFF, 32'h0000_0001);
        test_basic(32'h0000_0005, 32'h3333_3333);
        test_even();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/nprime0_calc.md
# nprime0_calc

Computes the Montgomery constant n'0 = −n0⁻¹ mod 2^DATA_WIDTH from the least-significant modulus word n0 using a bit-serial add/shift algorithm. It sits directly upstream of the nprime0 single-word memory. It replaces the precomputed `nprime0Mem.mif` contents when the modulus changes at run time, presenting the result on a one-word write port. The ModExp controller starts it once per new modulus and waits for `done`.

## Interface
- `DATA_WIDTH`: default `` `DATA_WIDTH `` (32 in benches); word width of n0 and n'0.
- `clock`: in, 1; single clock, rising edge.
- `reset`: in, 1; asynchronous, active-high.
- `start`: in, 1; request a computation, sampled only in IDLE.
- `n0`: in, DATA_WIDTH; low modulus word, sampled on the accepting edge.
- `busy`: out, 1; high while a computation is in progress.
- `done`: out, 1; one-cycle pulse when the result or error is valid.
- `err`: out, 1; set with `done` when n0 is even (no inverse); held until the next accepted `start`.
- `nprime0`: out, DATA_WIDTH; result register, held until the next successful computation.
- `wren`: out, 1; write strobe to nprime0 memory, equal to `done & ~err`.
- `address`: out, 1; constant 0.
- `data`: out, DATA_WIDTH; equals `nprime0`.

## Operation
- Algorithm on registers t, r (DATA_WIDTH bits each) and n (latched n0):
  - t = 0, r = 0.
  - For i = 0..DATA_WIDTH−1: if t[i] == 0, then t ← t + (n << i) mod 2^W and r[i] ← 1.
  - Final r satisfies n·r ≡ 2^W−1, so r = −n⁻¹ mod 2^W.
- All arithmetic is modulo 2^W. Carries out of bit W−1 are discarded. The shifted operand is truncated to W bits.
- FSM states:
  - IDLE: on `start`, latch n0, clear t, r, cnt and err. If n0[0] == 0, go to DONE with err ← 1. Otherwise go to RUN.
  - RUN: perform one iteration per cycle on bit cnt, then cnt ← cnt + 1. After the iteration with cnt == W−1, copy r to `nprime0` and go to DONE.
  - DONE: assert `done` (and `wren` if err is clear) for one cycle, then go to IDLE.
- `start` while not in IDLE is ignored, with no queuing.
- cnt width is clog2(DATA_WIDTH). It is compared against W−1, so there is no wrap-around dependence.
- The error path leaves `nprime0` unchanged.
- Reset values: state IDLE, busy 0, done 0, err 0, wren 0, nprime0 0, t/r/n/cnt 0, address 0.
- Reset asserted mid-RUN aborts immediately to reset values. No `done` is produced, and `nprime0` is cleared.

## Timing
- Edge k: `start` is sampled high in IDLE. busy = 1 from after edge k.
- Edges k+1 .. k+W: the W iterations (bit 0 at edge k+1).
- At edge k+W: `nprime0` updates, busy falls, and done/wren rise.
- At edge k+W+1: done/wren fall and the state is IDLE. A new `start` is accepted from edge k+W+1 onward.
- Total latency from start edge to done high is W cycles. Throughput is one result per W+1 cycles.
- Even n0: done/err are high in the cycle after edge k and busy is never raised.
- `busy` and `done` are never high together.
- `wren`/`address`/`data` satisfy the nprime0 memory write timing: data is stable in the same cycle as `wren`.

## Structure
- `DATA_WIDTH` comes from the shared `_parameter.v` include.
- State encoding localparams (IDLE, RUN, DONE) and the cnt width (clog2 of `DATA_WIDTH`) go in the shared parameter file alongside other ModExp controller states.
- Single flat module; no sub-module is warranted. The W-bit adder with shifter is inline combinational logic.

## Test plan
- n0 = 0x00000001, start -> done after 32 cycles, nprime0 = 0xFFFFFFFF, wren pulse 1 cycle, err = 0.
- n0 = 0x00000003 -> nprime0 = 0x55555555. n0 = 0xFFFFFFFF -> nprime0 = 0x00000001. Also 1000 random odd n0 checked against n0·nprime0 ≡ 0xFFFFFFFF.
- n0 = 0x00000002 -> done and err high in the cycle after start, busy never high, wren 0, nprime0 retains its previous value.
- `start` pulsed at cycles 5 and 20 of a run with a different n0 -> ignored; result matches the first n0 and the next start is accepted only after done.
- `reset` asserted at iteration 10 -> all outputs 0 immediately, no done; a fresh start then completes correctly.
- Back-to-back starts (start held high) -> successive done pulses spaced exactly 33 cycles apart.
